// File: rtl/camera_frame_capture.sv
// camera_frame_capture: OV7670 write-side front end.
// Registers the camera bus, pairs RGB565 bytes into RGB332 pixels and
// issues clipped X/Y writes into the frame buffer, one per stored pixel.
module camera_frame_capture #(
    parameter int   WIDTH     = 176,
    parameter int   HEIGHT    = 144,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        CAM_VSYNC,
    input  logic        CAM_HREF,
    input  logic [7:0]  CAM_DATA,
    output logic [7:0]  PIXEL_OUT,
    output logic [14:0] X_ADDR,
    output logic [14:0] Y_ADDR,
    output logic        W_EN,
    output logic        FRAME_DONE,
    output logic        CAPTURING
);

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SYNC       = 2'd1,
        ARMED      = 2'd2
    } state_t;

    localparam logic [14:0] WIDTH_C  = 15'(WIDTH);
    localparam logic [14:0] HEIGHT_C = 15'(HEIGHT);

    state_t      state_q, state_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic        href_prev_q, href_prev_d;
    logic [7:0]  data_q, data_d;
    logic        phase_q, phase_d;
    logic [5:0]  hi_q, hi_d;
    logic        line_lo_q, line_lo_d;
    logic [14:0] col_q, col_d;
    logic [14:0] row_q, row_d;
    logic [7:0]  pixel_q, pixel_d;
    logic [14:0] x_q, x_d;
    logic [14:0] y_q, y_d;
    logic        w_en_q, w_en_d;
    logic        frame_done_q, frame_done_d;

    logic vsync_active;
    logic href_fall;

    assign vsync_active = (vsync_q == VSYNC_POL);
    assign href_fall    = href_prev_q & ~href_q;

    // Next-state, byte pairing, clipping and write strobe generation
    always_comb begin
        vsync_d      = CAM_VSYNC;
        href_d       = CAM_HREF;
        data_d       = CAM_DATA;
        href_prev_d  = href_q;
        state_d      = state_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        line_lo_d    = line_lo_q;
        col_d        = col_q;
        row_d        = row_q;
        pixel_d      = pixel_q;
        x_d          = x_q;
        y_d          = y_q;
        w_en_d       = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            WAIT_FRAME: begin
                if (vsync_active) begin
                    state_d   = SYNC;
                    col_d     = '0;
                    row_d     = '0;
                    phase_d   = 1'b0;
                    line_lo_d = 1'b0;
                end
            end
            SYNC: begin
                if (!vsync_active) begin
                    state_d = ENABLE ? ARMED : WAIT_FRAME;
                end
            end
            ARMED: begin
                if (vsync_active) begin
                    frame_done_d = (row_q != '0);
                    state_d      = SYNC;
                    col_d        = '0;
                    row_d        = '0;
                    phase_d      = 1'b0;
                    line_lo_d    = 1'b0;
                end else if (href_q) begin
                    if (!phase_q) begin
                        hi_d    = {data_q[7:5], data_q[2:0]};
                        phase_d = 1'b1;
                    end else begin
                        phase_d   = 1'b0;
                        line_lo_d = 1'b1;
                        if ((col_q < WIDTH_C) && (row_q < HEIGHT_C)) begin
                            w_en_d  = 1'b1;
                            pixel_d = {hi_q, data_q[4:3]};
                            x_d     = col_q;
                            y_d     = row_q;
                        end
                        if (col_q < WIDTH_C) begin
                            col_d = col_q + 15'd1;
                        end
                    end
                end else if (href_fall) begin
                    col_d     = '0;
                    phase_d   = 1'b0;
                    line_lo_d = 1'b0;
                    if (line_lo_q && (row_q < HEIGHT_C)) begin
                        row_d = row_q + 15'd1;
                    end
                end
            end
            default: begin
                state_d = WAIT_FRAME;
            end
        endcase
    end

    // State, input sampling and output registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= WAIT_FRAME;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            href_prev_q  <= 1'b0;
            data_q       <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            line_lo_q    <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            pixel_q      <= '0;
            x_q          <= '0;
            y_q          <= '0;
            w_en_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            href_prev_q  <= href_prev_d;
            data_q       <= data_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            line_lo_q    <= line_lo_d;
            col_q        <= col_d;
            row_q        <= row_d;
            pixel_q      <= pixel_d;
            x_q          <= x_d;
            y_q          <= y_d;
            w_en_q       <= w_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign PIXEL_OUT  = pixel_q;
    assign X_ADDR     = x_q;
    assign Y_ADDR     = y_q;
    assign W_EN       = w_en_q;
    assign FRAME_DONE = frame_done_q;
    assign CAPTURING  = (state_q == ARMED);

endmodule

// File: tb/tb_camera_frame_capture.sv
// tb_camera_frame_capture: drives whole lines/frames of camera bytes and
// predicts every buffer write and frame-done pulse from the line contents.
module tb_camera_frame_capture;

    localparam int WIDTH  = 176;
    localparam int HEIGHT = 144;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        ENABLE = 1'b0;
    logic        CAM_VSYNC = 1'b0;
    logic        CAM_HREF = 1'b0;
    logic [7:0]  CAM_DATA = 8'h00;
    logic [7:0]  PIXEL_OUT;
    logic [14:0] X_ADDR;
    logic [14:0] Y_ADDR;
    logic        W_EN;
    logic        FRAME_DONE;
    logic        CAPTURING;

    camera_frame_capture #(
        .WIDTH(WIDTH),
        .HEIGHT(HEIGHT),
        .VSYNC_POL(1'b1)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .ENABLE(ENABLE),
        .CAM_VSYNC(CAM_VSYNC),
        .CAM_HREF(CAM_HREF),
        .CAM_DATA(CAM_DATA),
        .PIXEL_OUT(PIXEL_OUT),
        .X_ADDR(X_ADDR),
        .Y_ADDR(Y_ADDR),
        .W_EN(W_EN),
        .FRAME_DONE(FRAME_DONE),
        .CAPTURING(CAPTURING)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] pix;
        int         x;
        int         y;
    } wr_t;

    wr_t        wq[$];
    int         dq[$];
    logic [7:0] preset[$];
    logic [7:0] seenPix[$];

    int   vectors = 0;
    int   miscompares = 0;
    bit   checking = 1'b0;
    bit   capNow = 1'b0;
    bit   capNext = 1'b0;
    int   capAt = 32'h7fffffff;
    bit   mArmed = 1'b0;
    int   mRow = 0;
    int   nWrites = 0;
    int   nDone = 0;
    int   lastX = 0;
    int   lastY = 0;
    logic [7:0] lastPix = 8'h00;

    // Compare one observed value with its expectation and log a failure
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    function automatic logic [7:0] pack332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

    // Drive one camera bus cycle
    task automatic applyStimulus(input logic v, input logic h, input logic [7:0] d);
        @(negedge CLK);
        CAM_VSYNC = v;
        CAM_HREF  = h;
        CAM_DATA  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'($urandom));
    endtask

    // Send one HREF line; expected writes are derived from the byte pairs
    task automatic sendLine(input int nbytes, input int gap, input int mode, input int lineIdx);
        logic [7:0] b[];
        int s;
        b = new[nbytes];
        for (int i = 0; i < nbytes; i++) begin
            if (preset.size() > 0) b[i] = preset.pop_front();
            else if (mode == 1)    b[i] = 8'(i + lineIdx);
            else                   b[i] = 8'($urandom);
        end
        @(negedge CLK);
        s = cyc;
        if (mArmed) begin
            for (int k = 0; 2 * k + 1 < nbytes; k++) begin
                if (k < WIDTH && mRow < HEIGHT)
                    wq.push_back('{s + 2 * k + 3, pack332(b[2 * k], b[2 * k + 1]), k, mRow});
            end
        end
        CAM_VSYNC = 1'b0;
        CAM_HREF  = 1'b1;
        CAM_DATA  = b[0];
        for (int i = 1; i < nbytes; i++) applyStimulus(1'b0, 1'b1, b[i]);
        for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 8'($urandom));
        if (gap > 0 && mArmed && nbytes >= 2) mRow++;
    endtask

    // Vertical sync pulse; ENABLE value en is what the next frame sees
    task automatic vsyncPulse(input bit keepHref, input bit en);
        int c;
        int d;
        @(negedge CLK);
        c = cyc;
        CAM_VSYNC = 1'b1;
        CAM_HREF  = keepHref;
        CAM_DATA  = 8'($urandom);
        ENABLE    = en;
        if (mArmed) begin
            if (mRow >= 1) dq.push_back(c + 2);
            capNext = 1'b0;
            capAt   = c + 2;
        end
        repeat (3) applyStimulus(1'b1, 1'b0, 8'($urandom));
        @(negedge CLK);
        d = cyc;
        CAM_VSYNC = 1'b0;
        CAM_HREF  = 1'b0;
        mArmed = en;
        mRow   = 0;
        if (en) begin
            capNext = 1'b1;
            capAt   = d + 2;
        end
        idle(3);
    endtask

    // Every-cycle comparison of DUT outputs against the model queues
    always @(negedge CLK) begin
        if (checking) begin
            bit expW;
            bit expD;
            if (cyc >= capAt) capNow = capNext;
            checkOutput("capturing", 32'(CAPTURING), 32'(capNow));
            expW = (wq.size() > 0) && (wq[0].at == cyc);
            checkOutput("w_en", 32'(W_EN), 32'(expW));
            if (W_EN === 1'b1) begin
                nWrites++;
                lastX   = int'(X_ADDR);
                lastY   = int'(Y_ADDR);
                lastPix = PIXEL_OUT;
                seenPix.push_back(PIXEL_OUT);
            end
            if (expW) begin
                if (W_EN === 1'b1) begin
                    checkOutput("pixel_out", 32'(PIXEL_OUT), 32'(wq[0].pix));
                    checkOutput("x_addr", 32'(X_ADDR), 32'(wq[0].x));
                    checkOutput("y_addr", 32'(Y_ADDR), 32'(wq[0].y));
                end
                void'(wq.pop_front());
            end
            expD = (dq.size() > 0) && (dq[0] == cyc);
            checkOutput("frame_done", 32'(FRAME_DONE), 32'(expD));
            if (FRAME_DONE === 1'b1) nDone++;
            if (expD) void'(dq.pop_front());
        end
    end

    initial begin
        #1 RESET = 1'b0;
        // Reset held with random bus activity: all outputs stay 0
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            CAM_VSYNC = 1'($urandom);
            CAM_HREF  = 1'($urandom);
            CAM_DATA  = 8'($urandom);
            ENABLE    = 1'($urandom);
            checkOutput("rst_pixel", 32'(PIXEL_OUT), 32'd0);
            checkOutput("rst_x", 32'(X_ADDR), 32'd0);
            checkOutput("rst_y", 32'(Y_ADDR), 32'd0);
            checkOutput("rst_w_en", 32'(W_EN), 32'd0);
            checkOutput("rst_done", 32'(FRAME_DONE), 32'd0);
            checkOutput("rst_capturing", 32'(CAPTURING), 32'd0);
        end
        @(negedge CLK);
        CAM_VSYNC = 1'b0;
        CAM_HREF  = 1'b0;
        CAM_DATA  = 8'h00;
        ENABLE    = 1'b0;
        RESET     = 1'b1;
        checking  = 1'b1;
        idle(3);

        // First line: red pixel at origin
        vsyncPulse(1'b0, 1'b1);
        preset.push_back(8'hE0); preset.push_back(8'h00);
        sendLine(2, 2, 0, 0);
        idle(3);
        checkOutput("first_pix", 32'(lastPix), 32'h0E0);
        checkOutput("first_x", 32'(lastX), 32'd0);
        checkOutput("first_y", 32'(lastY), 32'd0);

        // Colour packing on line 1
        seenPix.delete();
        preset.push_back(8'h07); preset.push_back(8'h18);
        preset.push_back(8'h00); preset.push_back(8'h18);
        sendLine(4, 2, 0, 1);
        idle(3);
        checkOutput("pack_count", 32'(seenPix.size()), 32'd2);
        if (seenPix.size() == 2) begin
            checkOutput("pack_1f", 32'(seenPix[0]), 32'h01F);
            checkOutput("pack_03", 32'(seenPix[1]), 32'h003);
        end
        checkOutput("pack_y", 32'(lastY), 32'd1);

        // Odd-length line and a lone HI byte line
        nWrites = 0;
        sendLine(7, 2, 0, 2);
        idle(2);
        checkOutput("odd_writes", 32'(nWrites), 32'd3);
        sendLine(1, 3, 0, 3);
        sendLine(2, 2, 0, 4);
        idle(3);
        checkOutput("row_after_short", 32'(lastY), 32'd3);
        for (int l = 0; l < 4; l++) sendLine(2 * $urandom_range(1, 30) + $urandom_range(0, 1), $urandom_range(1, 4), 0, l);

        // Mid-line abort at column 50
        nDone = 0;
        sendLine(100, 0, 0, 9);
        vsyncPulse(1'b1, 1'b1);
        idle(3);
        checkOutput("abort_last_x", 32'(lastX), 32'd49);
        checkOutput("abort_done", 32'(nDone), 32'd1);
        sendLine(2, 2, 0, 0);
        idle(3);
        checkOutput("restart_x", 32'(lastX), 32'd0);
        checkOutput("restart_y", 32'(lastY), 32'd0);
        sendLine(10, 2, 0, 1);
        sendLine(10, 0, 0, 2);
        vsyncPulse(1'b0, 1'b1);

        // Only line ends together with VSYNC: row is 0, so no FRAME_DONE
        nDone = 0;
        sendLine(6, 0, 0, 0);
        vsyncPulse(1'b0, 1'b0);
        idle(3);
        checkOutput("simul_no_done", 32'(nDone), 32'd0);

        // Disabled frame, ENABLE raised mid-frame
        nWrites = 0;
        nDone = 0;
        sendLine(20, 2, 0, 0);
        ENABLE = 1'b1;
        sendLine(20, 2, 0, 1);
        vsyncPulse(1'b0, 1'b1);
        checkOutput("disabled_writes", 32'(nWrites), 32'd0);
        checkOutput("disabled_done", 32'(nDone), 32'd0);
        sendLine(10, 2, 0, 0);
        ENABLE = 1'b0;
        sendLine(10, 2, 0, 1);
        idle(2);
        checkOutput("enable_drop_writes", 32'(nWrites), 32'd10);
        vsyncPulse(1'b0, 1'b1);

        // Full frame with column and row overrun
        nWrites = 0;
        nDone = 0;
        for (int l = 0; l < 146; l++) sendLine(360, 2, 1, l);
        vsyncPulse(1'b0, 1'b0);
        idle(5);
        checkOutput("frame_writes", 32'(nWrites), 32'd25344);
        checkOutput("frame_last_x", 32'(lastX), 32'd175);
        checkOutput("frame_last_y", 32'(lastY), 32'd143);
        checkOutput("frame_done_count", 32'(nDone), 32'd1);

        idle(5);
        checkOutput("pending_writes", 32'(wq.size()), 32'd0);
        checkOutput("pending_done", 32'(dq.size()), 32'd0);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/camera_frame_capture.md
Name: camera_frame_capture

Overview:
- Write-side front end of the frame buffer. Samples the OV7670 parallel bus (VSYNC, HREF, D[7:0]), packs RGB565 byte pairs into RGB332 pixels, and drives pixel data, X/Y write address and write enable into the dual-port M9K.
- The VGA path reads that buffer on the other port.
- Clipping keeps all writes inside the SCREEN_WIDTH x SCREEN_HEIGHT buffer.
- Reports frame completion to the rest of the design.

Parameters:
- WIDTH, 176, pixels per line stored; columns at or beyond this are dropped.
- HEIGHT, 144, lines per frame stored; rows at or beyond this are dropped.
- VSYNC_POL, 1, level of CAM_VSYNC that marks vertical blanking (1 = high).

Ports:
- CLK  input  1  camera pixel clock (PCLK); all logic rising-edge.
- RESET  input  1  asynchronous, active-low reset (asserted when 0).
- ENABLE  input  1  capture enable; sampled only at frame start.
- CAM_VSYNC  input  1  camera vertical sync.
- CAM_HREF  input  1  camera line-valid; high while bytes are valid.
- CAM_DATA  input  8  camera data byte.
- PIXEL_OUT  output  8  RGB332 pixel to RAM input_data.
- X_ADDR  output  15  column of PIXEL_OUT.
- Y_ADDR  output  15  row of PIXEL_OUT.
- W_EN  output  1  RAM write enable, one cycle per stored pixel.
- FRAME_DONE  output  1  one-cycle pulse at the end of a captured frame.
- CAPTURING  output  1  high while in an armed frame.

Behaviour:
- Reset (RESET=0, async): PIXEL_OUT=0, X_ADDR=0, Y_ADDR=0, W_EN=0, FRAME_DONE=0, CAPTURING=0, byte phase=0, state=WAIT_FRAME. Internal line/column counters are cleared.
- All CAM_* inputs are registered once on CLK. All decisions use the registered copies.
- State WAIT_FRAME: wait for VSYNC active. Go to SYNC and clear counters.
- State SYNC: wait for VSYNC inactive. On exit, sample ENABLE: 1 -> ARMED (CAPTURING=1), 0 -> WAIT_FRAME.
- State ARMED: byte capture is active while HREF=1.
- Byte pairing while HREF=1:
  - phase 0: latch the byte as HI and set phase=1.
  - phase 1: the byte is LO. Form pixel {HI[7:5], HI[2:0], LO[4:3]} (R[4:2], G[5:3], B[4:3]) and set phase=0.
- Write timing: the cycle after a LO byte is registered, W_EN=1 for exactly one cycle.
  - PIXEL_OUT, X_ADDR and Y_ADDR hold that pixel's value and column/row in the same cycle.
  - The column counter then increments.
  - Pipeline latency from LO byte at the pins to W_EN is 2 CLK cycles.
- Clipping: if column >= WIDTH or row >= HEIGHT, W_EN stays 0. Counters still advance; column saturates at WIDTH.
- HREF falling edge:
  - column resets to 0 and phase resets to 0.
  - row increments only if at least one LO byte was seen on that line; row saturates at HEIGHT.
- Odd byte count: if HREF drops at phase 1, the dangling HI byte is discarded and nothing is written.
- VSYNC active while ARMED:
  - FRAME_DONE pulses for 1 cycle if row >= 1; otherwise no pulse.
  - CAPTURING drops to 0, counters clear, state goes to SYNC. The next frame re-samples ENABLE.
- VSYNC active mid-line (HREF=1): the line is aborted; the previous rule applies.
- VSYNC and an HREF falling edge in the same cycle: VSYNC wins. Row does not increment before FRAME_DONE.
- ENABLE dropping mid-frame has no effect until the next SYNC exit.
- Address width: counters are 15-bit. The top level forms address = X + Y*WIDTH; the maximum, 25343, fits in 15 bits.

Test Plan:
- Reset: hold RESET=0 with random CAM_* activity -> all outputs 0. Release, then issue VSYNC pulse, HREF line 0 with bytes 0xE0,0x00 -> W_EN at X=0, Y=0, PIXEL_OUT=0xE0 (red).
- Colour packing: pair 0x07,0x18 -> PIXEL_OUT=0x1F. Pair 0x00,0x18 -> 0x03 (blue). W_EN exactly 2 cycles after LO at the pins.
- Full frame: 144 lines x 352 bytes (counting pattern) -> exactly 25344 W_EN pulses, last at X=175, Y=143. One FRAME_DONE at the next VSYNC.
- Clipping: lines of 400 bytes and 150 lines -> no W_EN with X>=176 or Y>=144. Write count is still 25344.
- Odd bytes and abort: a 7-byte line -> 3 writes. VSYNC asserted mid-line at column 50 -> no further writes, FRAME_DONE pulse, next frame starts at X=0, Y=0.
- ENABLE gating: ENABLE=0 at SYNC exit -> zero W_EN for the whole frame and no FRAME_DONE. ENABLE=1 raised mid-frame -> capture begins only on the following frame.
